seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised, clocked successor to the 8-bit combinational ALU. Adds registered outputs,
//  status flags, a start/busy/done handshake, XOR, and an iterative shift-add multiply.
//  Shifts run one bit per cycle unless FAST_SHIFT is set.
//  Sits between the register file and the writeback mux; the controller stalls on busy.
// PARAMETERS
//  WIDTH       8   operand/result width in bits (>=4)
//  FAST_SHIFT  0   1: LS/RS complete in one cycle (barrel); 0: one bit per cycle
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; accepted on a rising edge only while busy=0
//  opcode  in   3      ADD=0 SUB=1 AND=2 OR=3 LS=4 RS=5 MUL=6 XOR=7
//  in1     in   WIDTH  operand A (unsigned bits; signed view only for ovf)
//  in2     in   WIDTH  operand B; for LS/RS, unsigned shift amount
//  busy    out  1      multi-cycle operation in progress
//  done    out  1      one-cycle pulse: out/out_hi/flags updated this cycle
//  out     out  WIDTH  result (low half for MUL)
//  out_hi  out  WIDTH  MUL high half; 0 for every other op
//  carry   out  1      ADD carry-out | SUB borrow (in1<in2 unsigned) | LS/RS last bit out | MUL out_hi!=0
//  zero    out  1      out==0 (MUL: low half only)
//  neg     out  1      out[WIDTH-1]
//  ovf     out  1      signed overflow for ADD/SUB; 0 otherwise
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy, done, out, out_hi, carry, zero, neg, ovf = 0.
//    Reset mid-operation aborts it; no done follows.
//  - Operands and opcode are latched at the accepting edge. Input changes while busy are ignored.
//    start while busy=1 is dropped (not queued).
//  - FSM states: IDLE, SHIFT, MUL.
//    IDLE + start, op in {ADD,SUB,AND,OR,XOR}, or LS/RS with k=0 or FAST_SHIFT=1:
//      result and flags registered at the accepting edge; done=1 the next cycle; stay in IDLE.
//    IDLE + start, LS/RS with k>0 and FAST_SHIFT=0: go to SHIFT, busy=1.
//      k = min(in2, WIDTH); one bit shifted per cycle, zero fill.
//      After the k-th shift, done=1, busy=0, return to IDLE. Latency is k+1 edges.
//    IDLE + start, MUL: go to MUL, busy=1. Shift-add over WIDTH iterations.
//      After the WIDTH-th iteration, done=1, busy=0, return to IDLE. Latency is WIDTH+1 edges.
//  - busy deasserts in the same cycle done rises. A new start may be accepted in that cycle (back-to-back).
//  - Shifts: in2 >= WIDTH yields out=0. carry = last bit shifted out (LS: in1[WIDTH-k]; RS: in1[k-1]).
//    k=0 gives out=in1, carry=0. FAST_SHIFT=1 produces identical results.
//  - Arithmetic is modulo 2^WIDTH. MUL is unsigned, full 2*WIDTH product {out_hi,out}.
//  - Flags are computed from the final result and update only with done. Outputs hold between results.
//  - done is never high for two consecutive cycles for the same operation.
// TESTING (WIDTH=8 unless noted)
//  1. ADD 5+2: out=7, all flags 0, done 1 cycle after accept.
//     ADD 200+100: out=44, carry=1, ovf=0.
//  2. SUB 5-7: out=0xFE, carry=1, neg=1, ovf=0.
//     SUB 0x80-1: out=0x7F, ovf=1.
//  3. LS 0x81 by 3, FAST_SHIFT=0: busy high 3 cycles, done at edge 4, out=0x08, carry=0.
//     RS 0x81 by 1: out=0x40, carry=1.
//     LS by 9: out=0, carry=in1[0].
//  4. MUL 200*3: done at edge 9, out=0x58, out_hi=0x02, carry=1, zero=0.
//     MUL 0*x: zero=1.
//  5. start pulsed while MUL is busy: ignored; single done; result is the first operation's.
//     start held during the done cycle: next op accepted back-to-back.
//  6. rst_n low 4 cycles into MUL: all outputs 0 immediately (async); no done after release.
//     Repeat tests 1-4 at WIDTH=16 with FAST_SHIFT=1.

Source files
------------

// File: rtl/seq_alu.sv
// Clocked ALU: ADD/SUB/AND/OR/XOR/LS/RS/MUL with registered result and status flags.
// Latency: 1 edge for single-cycle ops, k+1 for serial shifts, WIDTH+1 for MUL.
// Backpressure: busy=1 while a serial op runs; start is only accepted while busy=0, otherwise dropped.
module seq_alu #(
  parameter int WIDTH      = 8,
  parameter bit FAST_SHIFT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_LS  = 3'd4;
  localparam logic [2:0] OP_RS  = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    K_MAX = CW'(WIDTH);
  localparam logic [CW-1:0]    K_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] outhi_q;
  logic             carry_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;

  // Working registers for the serial operations
  logic [WIDTH-1:0] a_q;     // shift value, or MUL multiplicand
  logic [WIDTH-1:0] acc_q;   // MUL high-half accumulator
  logic [WIDTH-1:0] lo_q;    // MUL multiplier, shifted out as product low bits come in
  logic [CW-1:0]    cnt_q;   // remaining steps
  logic             dir_q;   // 1: left shift, 0: right shift

  // Single-cycle results computed straight from the inputs
  logic [CW-1:0]    k_d;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   ls_ext;
  logic [WIDTH:0]   rs_ext;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic             serial_shift_d;

  // One step of the serial shift / shift-add multiply
  logic [WIDTH-1:0] shift_nx;
  logic             shift_co;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;

  // Combinational ALU for everything that finishes at the accepting edge.
  // Shifts are done on a one-bit-wider vector so the last bit out lands in the extra bit.
  always_comb begin
    k_d     = (in2 >= W_VAL) ? K_MAX : in2[CW-1:0];
    add_ext = {1'b0, in1} + {1'b0, in2};
    sub_ext = {1'b0, in1} - {1'b0, in2};
    ls_ext  = {1'b0, in1} << k_d;
    rs_ext  = {in1, 1'b0} >> k_d;
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_d   = add_ext[WIDTH-1:0];
        carry_d = add_ext[WIDTH];
        ovf_d   = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_ext[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = sub_ext[WIDTH-1:0];
        carry_d = sub_ext[WIDTH];   // borrow: set exactly when in1 < in2
        ovf_d   = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_ext[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND: res_d = in1 & in2;
      OP_OR:  res_d = in1 | in2;
      OP_XOR: res_d = in1 ^ in2;
      OP_LS: begin
        res_d   = ls_ext[WIDTH-1:0];
        carry_d = ls_ext[WIDTH];
      end
      OP_RS: begin
        res_d   = rs_ext[WIDTH:1];
        carry_d = rs_ext[0];
      end
      default: ;
    endcase
    serial_shift_d = ((opcode == OP_LS) || (opcode == OP_RS)) && !FAST_SHIFT && (k_d != '0);
  end

  // Next values of the serial datapaths, consumed by the FSM each busy cycle
  always_comb begin
    if (dir_q) begin
      shift_nx = {a_q[WIDTH-2:0], 1'b0};
      shift_co = a_q[WIDTH-1];
    end else begin
      shift_nx = {1'b0, a_q[WIDTH-1:1]};
      shift_co = a_q[0];
    end
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

  // Control FSM with registered result, flags and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      outhi_q <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (opcode == OP_MUL) begin
              state_q <= S_MUL;
              busy_q  <= 1'b1;
              a_q     <= in1;
              lo_q    <= in2;
              acc_q   <= '0;
              cnt_q   <= K_MAX;
            end else if (serial_shift_d) begin
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
              a_q     <= in1;
              dir_q   <= (opcode == OP_LS);
              cnt_q   <= k_d;
            end else begin
              done_q  <= 1'b1;
              out_q   <= res_d;
              outhi_q <= '0;
              carry_q <= carry_d;
              zero_q  <= (res_d == '0);
              neg_q   <= res_d[WIDTH-1];
              ovf_q   <= ovf_d;
            end
          end
        end
        S_SHIFT: begin
          a_q   <= shift_nx;
          cnt_q <= cnt_q - K_ONE;
          if (cnt_q == K_ONE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= shift_nx;
            outhi_q <= '0;
            carry_q <= shift_co;
            zero_q  <= (shift_nx == '0);
            neg_q   <= shift_nx[WIDTH-1];
            ovf_q   <= 1'b0;
          end
        end
        S_MUL: begin
          acc_q <= mul_hi_nx;
          lo_q  <= mul_lo_nx;
          cnt_q <= cnt_q - K_ONE;
          if (cnt_q == K_ONE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= mul_lo_nx;
            outhi_q <= mul_hi_nx;
            carry_q <= (mul_hi_nx != '0);
            zero_q  <= (mul_lo_nx == '0);
            neg_q   <= mul_lo_nx[WIDTH-1];
            ovf_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign out    = out_q;
  assign out_hi = outhi_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign neg    = neg_q;
  assign ovf    = ovf_q;

endmodule
